dual_beam_scaler: RTL and testbench

DUAL_BEAM_SCALER -- requirements
Module: dual_beam_scaler

---
 rtl/pueo_beam_scaler_pkg.sv | 18 +
 rtl/beam_trig_holdoff.sv | 96 +++++++++
 rtl/dual_beam_scaler.sv | 177 +++++++++++++++++
 tb/tb_dual_beam_scaler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pueo_beam_scaler_pkg.sv
// pueo_beam_scaler_pkg
//   Shared constants and types for the dual-beam trigger scaler.
//   NTRIG         : number of trigger bits (beam A th0/th1, beam B th0/th1)
//   *_DEF         : default widths for the scaler, holdoff and period values
//   scaler_state_t: IDLE (disabled) / RUN (counting) state encoding
package pueo_beam_scaler_pkg;

   localparam int NTRIG            = 4;
   localparam int SC_BITS_DEF      = 16;
   localparam int HOLDOFF_BITS_DEF = 8;
   localparam int PERIOD_BITS_DEF  = 24;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } scaler_state_t;

endpackage

// File: rtl/beam_trig_holdoff.sv
// beam_trig_holdoff
//   One trigger bit: holdoff (dead-time) gating, registered output pulse and
//   a saturating event accumulator that restarts at each period boundary.
//   Ports:
//     clk       in   clock
//     rst       in   asynchronous active-high reset
//     run       in   1 = counting; 0 = counter, accumulator and pulse held at 0
//     trigger   in   raw trigger bit
//     holdoff   in   dead-time loaded on each accepted event
//     period_end in  terminal-count clock of the scaler period
//     trig      out  registered pulse, one clock after each accepted event
//     count     out  current accumulator value (sampled by the bank latch)
module beam_trig_holdoff
   import pueo_beam_scaler_pkg::*;
#(
   parameter int SC_BITS      = SC_BITS_DEF,
   parameter int HOLDOFF_BITS = HOLDOFF_BITS_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    run,
   input  logic                    trigger,
   input  logic [HOLDOFF_BITS-1:0] holdoff,
   input  logic                    period_end,
   output logic                    trig,
   output logic [SC_BITS-1:0]      count
);

   localparam logic [HOLDOFF_BITS-1:0] HOLD_ZERO = '0;
   localparam logic [HOLDOFF_BITS-1:0] HOLD_ONE  = HOLDOFF_BITS'(1);
   localparam logic [SC_BITS-1:0]      SC_ZERO   = '0;
   localparam logic [SC_BITS-1:0]      SC_ONE    = SC_BITS'(1);
   localparam logic [SC_BITS-1:0]      SC_MAX    = '1;

   logic [HOLDOFF_BITS-1:0] hold_cnt_r;
   logic [SC_BITS-1:0]      acc_r;
   logic                    trig_r;
   logic                    accept_s;

   // An event is accepted only while running and the dead-time has expired.
   always_comb begin
      accept_s = 1'b0;
      if (run && trigger && (hold_cnt_r == HOLD_ZERO)) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Dead-time counter: loads on accept, counts down to zero otherwise.
   // holdoff is only sampled at load time, so a change never disturbs a
   // count already in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt_r <= HOLD_ZERO;
      end else if (!run) begin
         hold_cnt_r <= HOLD_ZERO;
      end else if (accept_s) begin
         hold_cnt_r <= holdoff;
      end else if (hold_cnt_r != HOLD_ZERO) begin
         hold_cnt_r <= hold_cnt_r - HOLD_ONE;
      end else begin
         hold_cnt_r <= hold_cnt_r;
      end
   end

   // Saturating accumulator. On the period boundary the old value is taken
   // by the bank latch and an event accepted on that same clock opens the
   // new period with a count of one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r <= SC_ZERO;
      end else if (!run) begin
         acc_r <= SC_ZERO;
      end else if (period_end) begin
         acc_r <= accept_s ? SC_ONE : SC_ZERO;
      end else if (accept_s && (acc_r != SC_MAX)) begin
         acc_r <= acc_r + SC_ONE;
      end else begin
         acc_r <= acc_r;
      end
   end

   // Output pulse register (latency one clock from the accepting edge).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig_r <= 1'b0;
      end else begin
         trig_r <= accept_s;
      end
   end

   assign trig  = trig_r;
   assign count = acc_r;

endmodule

// File: rtl/dual_beam_scaler.sv
// dual_beam_scaler
//   Holdoff-gated trigger outputs plus periodic scalers for the four
//   dual-beam trigger bits. Four beam_trig_holdoff slices do the per-bit
//   work; this level owns the IDLE/RUN control, the period counter, the
//   latched scaler bank and the registered readout mux.
//   Ports:
//     clk_i        in   clock
//     rst_i        in   asynchronous active-high reset
//     trigger_i    in   [0] A th0, [1] A th1, [2] B th0, [3] B th1
//     enable_i     in   level enable (RUN when high)
//     holdoff_i    in   dead-time after each accepted event, all bits
//     period_i     in   scaler period in clocks (0 behaves as 1)
//     trig_o       out  holdoff-gated trigger pulses
//     sc_addr_i    in   selects the latched scaler to read
//     sc_dat_o     out  selected latched scaler, one clock after sc_addr_i
//     sc_update_o  out  one-clock pulse when a new bank is latched
module dual_beam_scaler
   import pueo_beam_scaler_pkg::*;
#(
   parameter int SC_BITS      = SC_BITS_DEF,
   parameter int HOLDOFF_BITS = HOLDOFF_BITS_DEF,
   parameter int PERIOD_BITS  = PERIOD_BITS_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NTRIG-1:0]        trigger_i,
   input  logic                    enable_i,
   input  logic [HOLDOFF_BITS-1:0] holdoff_i,
   input  logic [PERIOD_BITS-1:0]  period_i,
   output logic [NTRIG-1:0]        trig_o,
   input  logic [1:0]              sc_addr_i,
   output logic [SC_BITS-1:0]      sc_dat_o,
   output logic                    sc_update_o
);

   localparam logic [PERIOD_BITS-1:0] PERIOD_ZERO = '0;
   localparam logic [PERIOD_BITS-1:0] PERIOD_ONE  = PERIOD_BITS'(1);
   localparam logic [SC_BITS-1:0]     SC_ZERO     = '0;

   scaler_state_t           state_r;
   scaler_state_t           state_nxt_s;
   logic                    run_s;
   logic                    period_start_s;
   logic [PERIOD_BITS-1:0]  reload_s;
   logic [PERIOD_BITS-1:0]  cur_cnt_s;
   logic                    tc_s;
   logic [PERIOD_BITS-1:0]  pcnt_r;
   logic [SC_BITS-1:0]      count_s [NTRIG];
   logic [SC_BITS-1:0]      bank_r  [NTRIG];
   logic [NTRIG-1:0]        trig_s;
   logic [SC_BITS-1:0]      sc_dat_r;
   logic                    sc_update_r;

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state and run qualifiers. Leaving IDLE takes effect on the same
   // clock enable_i is seen high: that clock is the first of a new period
   // and triggers are already evaluated on it.
   always_comb begin
      state_nxt_s    = state_r;
      run_s          = 1'b0;
      period_start_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (enable_i) begin
               state_nxt_s    = ST_RUN;
               run_s          = 1'b1;
               period_start_s = 1'b1;
            end else begin
               state_nxt_s    = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (enable_i) begin
               state_nxt_s = ST_RUN;
               run_s       = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Reload value (period 0 behaves as period 1) and the effective count
   // for this clock. On a period start the count comes straight from the
   // reload value, so the counter contents after reset never matter.
   always_comb begin
      reload_s  = PERIOD_ZERO;
      cur_cnt_s = pcnt_r;
      tc_s      = 1'b0;
      if (period_i == PERIOD_ZERO) begin
         reload_s = PERIOD_ZERO;
      end else begin
         reload_s = period_i - PERIOD_ONE;
      end
      if (period_start_s) begin
         cur_cnt_s = reload_s;
      end else begin
         cur_cnt_s = pcnt_r;
      end
      tc_s = run_s && (cur_cnt_s == PERIOD_ZERO);
   end

   // Period counter: tracks the reload value while idle, counts down while
   // running, reloads on terminal count (period_i only sampled there).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pcnt_r <= PERIOD_ZERO;
      end else if (!run_s) begin
         pcnt_r <= reload_s;
      end else if (tc_s) begin
         pcnt_r <= reload_s;
      end else begin
         pcnt_r <= cur_cnt_s - PERIOD_ONE;
      end
   end

   // Latched bank: captures the accumulators on terminal count only, so a
   // partial period cut short by disable or reset is never published.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NTRIG; i++) begin
            bank_r[i] <= SC_ZERO;
         end
      end else if (tc_s) begin
         for (int i = 0; i < NTRIG; i++) begin
            bank_r[i] <= count_s[i];
         end
      end else begin
         for (int i = 0; i < NTRIG; i++) begin
            bank_r[i] <= bank_r[i];
         end
      end
   end

   // Update strobe and registered readout mux.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sc_update_r <= 1'b0;
         sc_dat_r    <= SC_ZERO;
      end else begin
         sc_update_r <= tc_s;
         sc_dat_r    <= bank_r[sc_addr_i];
      end
   end

   for (genvar g = 0; g < NTRIG; g++) begin : g_bit
      beam_trig_holdoff #(
         .SC_BITS      (SC_BITS),
         .HOLDOFF_BITS (HOLDOFF_BITS)
      ) u_holdoff (
         .clk        (clk_i),
         .rst        (rst_i),
         .run        (run_s),
         .trigger    (trigger_i[g]),
         .holdoff    (holdoff_i),
         .period_end (tc_s),
         .trig       (trig_s[g]),
         .count      (count_s[g])
      );
   end

   assign trig_o      = trig_s;
   assign sc_dat_o    = sc_dat_r;
   assign sc_update_o = sc_update_r;

endmodule

// File: tb/tb_dual_beam_scaler.sv
// tb_dual_beam_scaler
//   Self-checking bench for dual_beam_scaler. A table of per-clock vectors
//   drives the holdoff/accept path through a scoreboard queue; directed
//   sequences cover period latching, saturation (second instance with
//   4-bit scalers), terminal-count events, disable and async reset.
module tb_dual_beam_scaler;
   import pueo_beam_scaler_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  trigger;
   logic        enable;
   logic [7:0]  holdoff;
   logic [23:0] period;
   logic [1:0]  sc_addr;
   logic [3:0]  trig_o;
   logic [15:0] sc_dat;
   logic        sc_update;
   logic [3:0]  trig_o4;
   logic [3:0]  sc_dat4;
   logic        sc_update4;

   int tests = 0;
   int fails = 0;
   int n;
   int ups;

   typedef struct {
      logic       en;
      logic [3:0] trig;
      logic [7:0] hold;
      logic [3:0] exp_trig;
   } vec_t;

   vec_t       vecs [21];
   logic [3:0] exp_q [$];

   always #5 clk = ~clk;

   dual_beam_scaler dut (
      .clk_i(clk), .rst_i(rst), .trigger_i(trigger), .enable_i(enable),
      .holdoff_i(holdoff), .period_i(period), .trig_o(trig_o),
      .sc_addr_i(sc_addr), .sc_dat_o(sc_dat), .sc_update_o(sc_update)
   );

   dual_beam_scaler #(.SC_BITS(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .trigger_i(trigger), .enable_i(enable),
      .holdoff_i(holdoff), .period_i(period), .trig_o(trig_o4),
      .sc_addr_i(sc_addr), .sc_dat_o(sc_dat4), .sc_update_o(sc_update4)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Clocks until sc_update is seen (inclusive); a missing pulse is a failure.
   task automatic wait_update(input int bound, output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while ((sc_update !== 1'b1) && (cnt < bound));
      if (sc_update !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL wait_update: no sc_update within %0d clocks", bound);
      end
   endtask

   function automatic vec_t mk(input logic en, input logic [3:0] t, input logic [7:0] h, input logic [3:0] e);
      vec_t v;
      v.en = en; v.trig = t; v.hold = h; v.exp_trig = e;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // holdoff 3, bit 0 held for 10 clocks: accepts on clocks 0, 4, 8
      vecs[0]  = mk(1'b1, 4'b0001, 8'd3, 4'b0001);
      vecs[1]  = mk(1'b1, 4'b0001, 8'd3, 4'b0000);
      vecs[2]  = mk(1'b1, 4'b0001, 8'd3, 4'b0000);
      vecs[3]  = mk(1'b1, 4'b0001, 8'd3, 4'b0000);
      vecs[4]  = mk(1'b1, 4'b0001, 8'd3, 4'b0001);
      vecs[5]  = mk(1'b1, 4'b0001, 8'd3, 4'b0000);
      vecs[6]  = mk(1'b1, 4'b0001, 8'd3, 4'b0000);
      vecs[7]  = mk(1'b1, 4'b0001, 8'd3, 4'b0000);
      vecs[8]  = mk(1'b1, 4'b0001, 8'd3, 4'b0001);
      vecs[9]  = mk(1'b1, 4'b0001, 8'd3, 4'b0000);
      // bit 0 counter now 2 then 1: a holdoff change must not shorten it
      vecs[10] = mk(1'b1, 4'b0000, 8'd3, 4'b0000);
      vecs[11] = mk(1'b1, 4'b1111, 8'd0, 4'b1110);
      // holdoff 0: every high cycle accepted
      vecs[12] = mk(1'b1, 4'b1111, 8'd0, 4'b1111);
      vecs[13] = mk(1'b1, 4'b1111, 8'd2, 4'b1111);
      vecs[14] = mk(1'b1, 4'b1111, 8'd0, 4'b0000);
      vecs[15] = mk(1'b1, 4'b1111, 8'd0, 4'b0000);
      vecs[16] = mk(1'b1, 4'b1111, 8'd0, 4'b1111);
      vecs[17] = mk(1'b1, 4'b0101, 8'd0, 4'b0101);
      // disabled: nothing accepted; re-enable evaluates triggers at once
      vecs[18] = mk(1'b0, 4'b1111, 8'd0, 4'b0000);
      vecs[19] = mk(1'b1, 4'b1010, 8'd5, 4'b1010);
      vecs[20] = mk(1'b1, 4'b1010, 8'd5, 4'b0000);

      rst = 1'b1; enable = 1'b0; trigger = 4'b0000; holdoff = 8'd0;
      period = 24'd1000; sc_addr = 2'd0;
      tick();
      tick();
      check("reset_trig_o", {28'd0, trig_o}, 32'd0);
      check("reset_sc_update", {31'd0, sc_update}, 32'd0);
      check("reset_sc_dat", {16'd0, sc_dat}, 32'd0);
      check("reset_small_trig_o", {28'd0, trig_o4}, 32'd0);
      check("reset_small_update", {31'd0, sc_update4}, 32'd0);
      rst = 1'b0;
      tick();

      // table-driven holdoff/accept vectors through the scoreboard queue
      for (int i = 0; i < 21; i++) begin
         enable  = vecs[i].en;
         trigger = vecs[i].trig;
         holdoff = vecs[i].hold;
         exp_q.push_back(vecs[i].exp_trig);
         tick();
         check($sformatf("trig_vec%0d", i), {28'd0, trig_o}, {28'd0, exp_q.pop_front()});
      end

      // period 100, bit 2 always high. The event on the terminal-count clock
      // belongs to the next period, so the first bank holds 99, later ones 100.
      enable = 1'b0; trigger = 4'b0000; holdoff = 8'd0; period = 24'd100;
      tick();
      enable = 1'b1; trigger = 4'b0100;
      wait_update(300, n);
      check("p100_first_interval", n, 100);
      sc_addr = 2'd2; tick();
      check("p100_update_one_clock", {31'd0, sc_update}, 32'd0);
      check("p100_bank2_first", {16'd0, sc_dat}, 32'd99);
      sc_addr = 2'd0; tick(); check("p100_bank0", {16'd0, sc_dat}, 32'd0);
      sc_addr = 2'd1; tick(); check("p100_bank1", {16'd0, sc_dat}, 32'd0);
      sc_addr = 2'd3; tick(); check("p100_bank3", {16'd0, sc_dat}, 32'd0);
      wait_update(300, n);
      check("p100_second_interval", n, 96);  // 4 clocks spent on reads
      sc_addr = 2'd2; tick();
      check("p100_bank2_second", {16'd0, sc_dat}, 32'd100);

      // saturation: 4-bit instance must stick at 15 while 16-bit counts on
      enable = 1'b0; trigger = 4'b0000; period = 24'd40;
      tick();
      enable = 1'b1; trigger = 4'b0010;
      wait_update(200, n);
      check("p40_interval", n, 40);
      sc_addr = 2'd1; tick();
      check("p40_bank1_first", {16'd0, sc_dat}, 32'd39);
      check("sat_bank1_first", {28'd0, sc_dat4}, 32'd15);
      wait_update(200, n);
      check("p40_second_interval", n, 39);
      tick();
      check("p40_bank1_second", {16'd0, sc_dat}, 32'd40);
      check("sat_bank1_second", {28'd0, sc_dat4}, 32'd15);

      // event exactly on the terminal-count clock (10th clock of period 10)
      enable = 1'b0; trigger = 4'b0000; period = 24'd10;
      tick();
      enable = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         trigger = (k == 10) ? 4'b0001 : 4'b0000;
         tick();
         if (k == 9) check("tc_not_before", {31'd0, sc_update}, 32'd0);
         if (k == 10) check("tc_update", {31'd0, sc_update}, 32'd1);
      end
      trigger = 4'b0000; sc_addr = 2'd0; tick();
      check("tc_event_excluded", {16'd0, sc_dat}, 32'd0);
      wait_update(50, n);
      check("tc_next_interval", n, 9);
      tick();
      check("tc_event_next_bank", {16'd0, sc_dat}, 32'd1);

      // period 0 behaves as 1: bank latched every clock
      enable = 1'b0; trigger = 4'b0000; period = 24'd0;
      tick();
      enable = 1'b1; trigger = 4'b0001; sc_addr = 2'd0;
      tick(); check("p0_update_1", {31'd0, sc_update}, 32'd1);
      tick(); check("p0_update_2", {31'd0, sc_update}, 32'd1);
      check("p0_bank_first", {16'd0, sc_dat}, 32'd0);
      tick(); check("p0_update_3", {31'd0, sc_update}, 32'd1);
      check("p0_bank_next", {16'd0, sc_dat}, 32'd1);

      // disable after 37 events: partial period discarded, bank kept at 1
      enable = 1'b0; trigger = 4'b0000; period = 24'd100;
      tick();
      enable = 1'b1; trigger = 4'b0001; ups = 0;
      for (int k = 0; k < 37; k++) begin
         tick();
         if (sc_update === 1'b1) ups++;
      end
      check("partial_no_update", ups, 0);
      enable = 1'b0; trigger = 4'b0000;
      tick(); check("partial_disable_update", {31'd0, sc_update}, 32'd0);
      tick(); check("partial_bank_kept", {16'd0, sc_dat}, 32'd1);
      enable = 1'b1; trigger = 4'b0001;
      wait_update(300, n);
      check("reenable_full_period", n, 100);
      tick();
      check("reenable_bank_from_zero", {16'd0, sc_dat}, 32'd99);

      // async reset between edges while a long holdoff is running
      holdoff = 8'd200;
      tick();
      check("rst_pre_trig", {28'd0, trig_o}, 32'd1);
      check("rst_pre_dat", {16'd0, sc_dat}, 32'd99);
      #2 rst = 1'b1;
      #1;
      check("rst_async_trig", {28'd0, trig_o}, 32'd0);
      check("rst_async_update", {31'd0, sc_update}, 32'd0);
      check("rst_async_dat", {16'd0, sc_dat}, 32'd0);
      #1 rst = 1'b0;
      tick();
      check("rst_first_trig_accepted", {28'd0, trig_o}, 32'd1);
      check("rst_bank_cleared", {16'd0, sc_dat}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
